// File: rtl/line_mem_responder.sv
// Line refill/writeback responder: serves one cache-line request as word beats on a narrow memory bus.
// Build option LINE_MEM_RESPONDER_PIPELINED_READ_EN: issue read beats back-to-back instead of one at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a line request; write wins over read
// S_WRITE | issuing write beats, one word of the latched line per beat
// S_READ  | issuing read beats and assembling responses into the line
// S_DONE  | one-cycle done pulse for the latched op, then back to idle
module line_mem_responder #(
  parameter  int LINE_WIDTH     = 128,
  parameter  int BUS_WIDTH      = 32,
  parameter  int MEM_ADDR_WIDTH = 28,
  localparam int BEAT_COUNT     = LINE_WIDTH / BUS_WIDTH,
  localparam int BEAT_WIDTH     = $clog2(BEAT_COUNT)
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic [MEM_ADDR_WIDTH-1:0]          memAddr,
  input  logic                               memReadEnable,
  input  logic                               memWriteEnable,
  input  logic [LINE_WIDTH-1:0]              memWriteValue,
  output logic                               memReadDone,
  output logic                               memWriteDone,
  output logic [LINE_WIDTH-1:0]              memReadValue,
  output logic                               busValid,
  input  logic                               busReady,
  output logic                               busWrite,
  output logic [MEM_ADDR_WIDTH+BEAT_WIDTH-1:0] busAddr,
  output logic [BUS_WIDTH-1:0]               busWriteData,
  input  logic                               busReadValid,
  input  logic [BUS_WIDTH-1:0]               busReadData
);

  localparam int                CNT_W = BEAT_WIDTH + 1;
  localparam logic [CNT_W-1:0]  BEATS = CNT_W'(BEAT_COUNT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BEAT_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [LINE_WIDTH-1:0]     line, line_nxt;
  logic                      op_write, op_write_nxt;
  logic [CNT_W-1:0]          req_count, req_count_nxt;
  logic [CNT_W-1:0]          resp_count, resp_count_nxt;
  logic [BEAT_WIDTH-1:0]     req_idx, resp_idx;
  logic                      read_issue;

  assign req_idx  = req_count[BEAT_WIDTH-1:0];
  assign resp_idx = resp_count[BEAT_WIDTH-1:0];

`ifdef LINE_MEM_RESPONDER_PIPELINED_READ_EN
  assign read_issue = (req_count < BEATS);
`else
  // Only one read beat in flight: wait for its response before issuing the next.
  assign read_issue = (req_count == resp_count) && (req_count < BEATS);
`endif

  // All outputs decode registered state only; busReady/busReadValid never reach them.
  assign busValid     = (state == S_WRITE) || ((state == S_READ) && read_issue);
  assign busWrite     = (state == S_WRITE);
  assign busAddr      = {addr, req_idx};
  assign busWriteData = (state == S_WRITE) ? line[int'(req_idx)*BUS_WIDTH +: BUS_WIDTH] : '0;
  assign memReadDone  = (state == S_DONE) && !op_write;
  assign memWriteDone = (state == S_DONE) && op_write;
  assign memReadValue = line;

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    line_nxt       = line;
    op_write_nxt   = op_write;
    req_count_nxt  = req_count;
    resp_count_nxt = resp_count;
    case (state)
      S_IDLE: begin
        if (memWriteEnable) begin
          addr_nxt       = memAddr;
          line_nxt       = memWriteValue;
          op_write_nxt   = 1'b1;
          req_count_nxt  = '0;
          resp_count_nxt = '0;
          state_nxt      = S_WRITE;
        end else if (memReadEnable) begin
          addr_nxt       = memAddr;
          op_write_nxt   = 1'b0;
          req_count_nxt  = '0;
          resp_count_nxt = '0;
          state_nxt      = S_READ;
        end
      end
      S_WRITE: begin
        if (busReady) begin
          req_count_nxt = req_count + 1'b1;
          if (req_count == LAST) state_nxt = S_DONE;
        end
      end
      S_READ: begin
        if (busValid && busReady) req_count_nxt = req_count + 1'b1;
        // A response counts only against a beat that is actually outstanding.
        if (busReadValid && (resp_count < req_count)) begin
          line_nxt[int'(resp_idx)*BUS_WIDTH +: BUS_WIDTH] = busReadData;
          resp_count_nxt = resp_count + 1'b1;
          if (resp_count == LAST) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= S_IDLE;
      addr       <= '0;
      line       <= '0;
      op_write   <= 1'b0;
      req_count  <= '0;
      resp_count <= '0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      line       <= line_nxt;
      op_write   <= op_write_nxt;
      req_count  <= req_count_nxt;
      resp_count <= resp_count_nxt;
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: scoreboarded beats and done lines plus a latency-L memory model.
module tb_line_mem_responder;
  localparam int LW = 128;
  localparam int BW = 32;
  localparam int AW = 28;
  localparam int BC = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic [AW-1:0] memAddr;
  logic          memReadEnable, memWriteEnable;
  logic [LW-1:0] memWriteValue;
  logic          memReadDone, memWriteDone;
  logic [LW-1:0] memReadValue;
  logic          busValid, busReady, busWrite;
  logic [AW+1:0] busAddr;
  logic [BW-1:0] busWriteData;
  logic          busReadValid;
  logic [BW-1:0] busReadData;

  typedef struct packed {logic wr; logic [AW+1:0] addr; logic [BW-1:0] data;} beat_t;
  typedef struct {int due; logic [BW-1:0] data;} resp_t;

  beat_t         exp_beats[$];
  logic [LW-1:0] exp_lines[$];
  resp_t         pend[$];
  logic [LW-1:0] last_line;
  logic [BW-1:0] rd_base;
  int            lat = 2;
  int            gcyc = 0;
  int            checks = 0;
  int            failures = 0;

  line_mem_responder dut (
    .clk(clk), .rstN(rstN), .memAddr(memAddr), .memReadEnable(memReadEnable),
    .memWriteEnable(memWriteEnable), .memWriteValue(memWriteValue),
    .memReadDone(memReadDone), .memWriteDone(memWriteDone), .memReadValue(memReadValue),
    .busValid(busValid), .busReady(busReady), .busWrite(busWrite), .busAddr(busAddr),
    .busWriteData(busWriteData), .busReadValid(busReadValid), .busReadData(busReadData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) gcyc++;

  // Memory model, called once per cycle at the falling edge after busReady is set.
  task automatic bus_model();
    resp_t r;
    busReadValid = 1'b0;
    busReadData  = '0;
    if (pend.size() > 0 && pend[0].due == gcyc) begin
      busReadValid = 1'b1;
      busReadData  = pend[0].data;
      void'(pend.pop_front());
    end
    if (busValid && busReady && !busWrite) begin
      r.due  = gcyc + lat;
      r.data = rd_base + 32'(busAddr[1:0]);
      pend.push_back(r);
    end
  endtask

  function automatic int read_done_cycle(input int l);
`ifdef LINE_MEM_RESPONDER_PIPELINED_READ_EN
    return BC + l + 1;
`else
    return BC * (l + 1) + 1;
`endif
  endfunction

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busValid, busWrite, busAddr, busWriteData} !== '0)
      $display("FAIL reset_bus: got %h expected 0", {busValid, busWrite, busAddr, busWriteData});
    checks++;
    if ({memReadDone, memWriteDone} !== 2'b00)
      $display("FAIL reset_done: got %b expected 00", {memReadDone, memWriteDone});
    checks++;
    if (memReadValue !== '0) $display("FAIL reset_line: got %h expected 0", memReadValue);
    if ({busValid, busWrite, busAddr, busWriteData} !== '0 || {memReadDone, memWriteDone} !== 2'b00 || memReadValue !== '0)
      failures++;
    rstN = 1'b1;
    @(negedge clk);
    checks++;
    if ({busValid, memReadDone, memWriteDone} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 000", {busValid, memReadDone, memWriteDone});
    end
  endtask

  task automatic test_write(input logic [AW-1:0] a, input logic [LW-1:0] w, input int stall);
    int ndone, done_c, nbeat;
    beat_t b, hold;
    ndone = 0; done_c = -1; nbeat = 0;
    for (int i = 0; i < BC; i++) exp_beats.push_back(beat_t'({1'b1, a, 2'(i), w[i*BW +: BW]}));
    hold = beat_t'({1'b1, a, 2'd1, w[BW +: BW]});
    @(negedge clk);
    memAddr = a; memWriteValue = w; memWriteEnable = 1'b1; busReady = 1'b1;
    bus_model();
    for (int c = 1; c <= BC + stall + 4; c++) begin
      @(negedge clk);
      busReady = !(c >= 2 && c < 2 + stall);
      bus_model();
      if (!busReady) begin
        checks++;
        if ({busValid, busWrite, busAddr, busWriteData} !== {1'b1, hold}) begin
          failures++;
          $display("FAIL stall_hold c=%0d: got %h expected %h", c, {busValid, busWrite, busAddr, busWriteData}, {1'b1, hold});
        end
      end
      if (busValid && busReady) begin
        checks++;
        if (exp_beats.size() == 0) begin
          failures++;
          $display("FAIL write_beat_extra: got beat %h expected none", {busWrite, busAddr, busWriteData});
        end else begin
          b = exp_beats.pop_front();
          if ({busWrite, busAddr, busWriteData} !== b) begin
            failures++;
            $display("FAIL write_beat: got %h expected %h", {busWrite, busAddr, busWriteData}, b);
          end
        end
        checks++;
        if (c != nbeat + 1 + ((nbeat >= 1) ? stall : 0)) begin
          failures++;
          $display("FAIL write_beat_cycle: got %0d expected %0d", c, nbeat + 1 + ((nbeat >= 1) ? stall : 0));
        end
        nbeat++;
      end
      checks++;
      if (memReadDone !== 1'b0) begin
        failures++;
        $display("FAIL write_no_read_done: got %b expected 0", memReadDone);
      end
      if (memWriteDone) begin ndone++; done_c = c; memWriteEnable = 1'b0; end
    end
    busReady = 1'b1;
    checks++;
    if (ndone != 1 || done_c != 5 + stall) begin
      failures++;
      $display("FAIL write_done: got count=%0d cycle=%0d expected count=1 cycle=%0d", ndone, done_c, 5 + stall);
    end
    checks++;
    if (exp_beats.size() != 0) begin
      failures++;
      $display("FAIL write_beats_left: got %0d expected 0", exp_beats.size());
      exp_beats.delete();
    end
  endtask

  task automatic test_read(input logic [AW-1:0] a, input logic [BW-1:0] base, input int l);
    int ndone, done_c;
    logic [LW-1:0] e;
    beat_t b;
    ndone = 0; done_c = -1;
    for (int i = 0; i < BC; i++) begin
      e[i*BW +: BW] = base + 32'(i);
      exp_beats.push_back(beat_t'({1'b0, a, 2'(i), 32'h0}));
    end
    exp_lines.push_back(e);
    last_line = e;
    rd_base = base; lat = l;
    @(negedge clk);
    memAddr = a; memReadEnable = 1'b1; busReady = 1'b1;
    bus_model();
    for (int c = 1; c <= read_done_cycle(l) + 3; c++) begin
      @(negedge clk);
      bus_model();
      if (busValid && busReady) begin
        checks++;
        if (exp_beats.size() == 0) begin
          failures++;
          $display("FAIL read_beat_extra: got addr %h expected none", busAddr);
        end else begin
          b = exp_beats.pop_front();
          if ({busWrite, busAddr} !== {b.wr, b.addr}) begin
            failures++;
            $display("FAIL read_beat: got %h expected %h", {busWrite, busAddr}, {b.wr, b.addr});
          end
        end
      end
      checks++;
      if (memWriteDone !== 1'b0) begin
        failures++;
        $display("FAIL read_no_write_done: got %b expected 0", memWriteDone);
      end
      if (memReadDone) begin
        ndone++; done_c = c; memReadEnable = 1'b0;
        checks++;
        if (exp_lines.size() == 0) begin
          failures++;
          $display("FAIL read_line_extra: got %h expected none", memReadValue);
        end else begin
          e = exp_lines.pop_front();
          if (memReadValue !== e) begin
            failures++;
            $display("FAIL read_line: got %h expected %h", memReadValue, e);
          end
        end
      end
    end
    checks++;
    if (ndone != 1 || done_c != read_done_cycle(l)) begin
      failures++;
      $display("FAIL read_done: got count=%0d cycle=%0d expected count=1 cycle=%0d", ndone, done_c, read_done_cycle(l));
    end
    checks++;
    if (exp_beats.size() != 0 || pend.size() != 0) begin
      failures++;
      $display("FAIL read_leftover: got beats=%0d resp=%0d expected 0 0", exp_beats.size(), pend.size());
      exp_beats.delete(); pend.delete();
    end
  endtask

  task automatic test_back_to_back(input logic [AW-1:0] a, input logic [LW-1:0] w,
                                   input logic [BW-1:0] base, input int l);
    int wdone, wdone_c, rdone, rdone_c, first_rd;
    logic [LW-1:0] e;
    beat_t b;
    wdone = 0; wdone_c = -1; rdone = 0; rdone_c = -1; first_rd = -1;
    for (int i = 0; i < BC; i++) exp_beats.push_back(beat_t'({1'b1, a, 2'(i), w[i*BW +: BW]}));
    for (int i = 0; i < BC; i++) begin
      e[i*BW +: BW] = base + 32'(i);
      exp_beats.push_back(beat_t'({1'b0, a, 2'(i), 32'h0}));
    end
    exp_lines.push_back(e);
    last_line = e;
    rd_base = base; lat = l;
    @(negedge clk);
    memAddr = a; memWriteValue = w; memWriteEnable = 1'b1; memReadEnable = 1'b1; busReady = 1'b1;
    bus_model();
    for (int c = 1; c <= 6 + read_done_cycle(l) + 3; c++) begin
      @(negedge clk);
      bus_model();
      if (busValid && busReady) begin
        checks++;
        if (exp_beats.size() == 0) begin
          failures++;
          $display("FAIL b2b_beat_extra: got %h expected none", {busWrite, busAddr});
        end else begin
          b = exp_beats.pop_front();
          if ({busWrite, busAddr} !== {b.wr, b.addr} || (b.wr && busWriteData !== b.data)) begin
            failures++;
            $display("FAIL b2b_beat: got %h expected %h", {busWrite, busAddr, busWriteData}, b);
          end
        end
        if (!busWrite && first_rd < 0) first_rd = c;
      end
      if (memWriteDone) begin wdone++; wdone_c = c; memWriteEnable = 1'b0; end
      if (memReadDone) begin
        rdone++; rdone_c = c; memReadEnable = 1'b0;
        checks++;
        if (exp_lines.size() == 0 || memReadValue !== exp_lines[0]) begin
          failures++;
          $display("FAIL b2b_line: got %h expected %h", memReadValue, e);
        end
        if (exp_lines.size() != 0) void'(exp_lines.pop_front());
      end
    end
    checks++;
    if (wdone != 1 || wdone_c != 5) begin
      failures++;
      $display("FAIL b2b_write_done: got count=%0d cycle=%0d expected count=1 cycle=5", wdone, wdone_c);
    end
    checks++;
    if (first_rd != 7) begin
      failures++;
      $display("FAIL b2b_read_start: got cycle %0d expected 7", first_rd);
    end
    checks++;
    if (rdone != 1 || rdone_c != 6 + read_done_cycle(l)) begin
      failures++;
      $display("FAIL b2b_read_done: got count=%0d cycle=%0d expected count=1 cycle=%0d", rdone, rdone_c, 6 + read_done_cycle(l));
    end
    checks++;
    if (exp_beats.size() != 0) begin
      failures++;
      $display("FAIL b2b_beats_left: got %0d expected 0", exp_beats.size());
      exp_beats.delete();
    end
  endtask

  task automatic test_reset_mid_read(input logic [AW-1:0] a, input logic [BW-1:0] base, input int l);
    int nresp, rst_c, ndone;
    nresp = 0; rst_c = -1; ndone = 0;
    rd_base = base; lat = l;
    @(negedge clk);
    memAddr = a; memReadEnable = 1'b1; busReady = 1'b1;
    bus_model();
    for (int c = 1; c <= 40 && (rst_c < 0 || c <= rst_c + 5); c++) begin
      @(negedge clk);
      if (rst_c < 0 && nresp == 2) begin
        rstN = 1'b0; memReadEnable = 1'b0;
        pend.delete();
        busReadValid = 1'b0; busReadData = '0;
        rst_c = c;
      end else begin
        if (c == rst_c + 1) begin
          rstN = 1'b1;
          checks++;
          if ({busValid, busWrite, busAddr, busWriteData} !== '0) begin
            failures++;
            $display("FAIL midreset_bus: got %h expected 0", {busValid, busWrite, busAddr, busWriteData});
          end
          checks++;
          if (memReadValue !== '0) begin
            failures++;
            $display("FAIL midreset_line: got %h expected 0", memReadValue);
          end
        end
        bus_model();
        if (busReadValid) nresp++;
      end
      if (memReadDone || memWriteDone) ndone++;
    end
    checks++;
    if (rst_c < 0 || ndone != 0) begin
      failures++;
      $display("FAIL midreset_done: got reset_cycle=%0d done_pulses=%0d expected reset applied and 0 pulses", rst_c, ndone);
    end
    test_read(a + 28'h1, base + 32'h10, l);
  endtask

  task automatic test_stray_response();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      busReadValid = (c == 0);
      busReadData  = (c == 0) ? 32'hFFFF_FFFF : 32'h0;
      checks++;
      if ({busValid, memReadDone, memWriteDone} !== 3'b000 || memReadValue !== last_line) begin
        failures++;
        $display("FAIL stray_ignored c=%0d: got flags=%b line=%h expected 000 line=%h",
                 c, {busValid, memReadDone, memWriteDone}, memReadValue, last_line);
      end
    end
    busReadValid = 1'b0;
  endtask

  initial begin
    memAddr = '0; memReadEnable = 1'b0; memWriteEnable = 1'b0; memWriteValue = '0;
    busReady = 1'b0; busReadValid = 1'b0; busReadData = '0;
    rd_base = '0; last_line = '0;
    test_reset();
    test_write(28'h0000010, 128'h33333333_22222222_11111111_00000000, 0);
    test_write(28'h0ABCDE1, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 3);
    test_read(28'h0000002, 32'hA0, 2);
    test_back_to_back(28'h0000155, 128'h44444444_55555555_66666666_77777777, 32'hC0, 1);
    test_reset_mid_read(28'h0000077, 32'hD0, 2);
    test_stray_response();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Memory-side responder for the data-cache line refill/writeback interface. Accepts one line-wide read or write request from the cache replacement logic and serves it as a sequence of word-wide beats on a narrow memory bus. Returns a one-cycle done pulse with the assembled line on reads. Sits between the D-cache replacer and the external memory bus.

## Interface
- LINE_WIDTH, 128: cache line width in bits; an integer multiple of BUS_WIDTH.
- BUS_WIDTH, 32: bus data width in bits.
- MEM_ADDR_WIDTH, 28: line address width, i.e. tag plus index.
- BEAT_COUNT, LINE_WIDTH/BUS_WIDTH: derived; beats per line; a power of two, at least 2.
- BEAT_WIDTH, $clog2(BEAT_COUNT): derived.
- clk  in  1  clock; single clock domain.
- rstN  in  1  reset; synchronous, active-low.
- memAddr  in  MEM_ADDR_WIDTH  line address; held stable while a request is active.
- memReadEnable  in  1  line read request; level, held until memReadDone.
- memWriteEnable  in  1  line write request; level, held until memWriteDone.
- memWriteValue  in  LINE_WIDTH  line to write.
- memReadDone  out  1  one-cycle pulse; memReadValue is valid in this cycle.
- memWriteDone  out  1  one-cycle pulse; the write has fully completed.
- memReadValue  out  LINE_WIDTH  assembled read line.
- busValid  out  1  beat request valid.
- busReady  in  1  beat request accepted when busValid && busReady.
- busWrite  out  1  1 = write beat, 0 = read beat.
- busAddr  out  MEM_ADDR_WIDTH+BEAT_WIDTH  word address = {line address, beat index}.
- busWriteData  out  BUS_WIDTH  write beat data.
- busReadValid  in  1  read response valid; no backpressure; responses return in order.
- busReadData  in  BUS_WIDTH  read response data.

## Operation
- States: Idle, Write, Read, Done. Registers: state, addr, line, op, reqCount, respCount (each 0..BEAT_COUNT).
- Idle:
  - memWriteEnable latches memAddr, memWriteValue, op=write, clears the counters, and moves to Write.
  - Otherwise memReadEnable latches memAddr, op=read, clears the counters, and moves to Read.
  - Write wins if both enables are high; the read stays pending and is accepted in a later Idle cycle.
- Write:
  - busValid=1, busWrite=1, busAddr={addr, reqCount}, busWriteData=line[reqCount*BUS_WIDTH +: BUS_WIDTH]. Beat 0 is the least significant word.
  - Each accepted beat increments reqCount.
  - On acceptance of the last beat, move to Done.
- Read:
  - busWrite=0 and busAddr={addr, reqCount}.
  - busValid=1 while reqCount<BEAT_COUNT, subject to the issue rule in Configuration.
  - Each busReadValid writes busReadData into line[respCount*BUS_WIDTH +: BUS_WIDTH] and increments respCount.
  - When respCount reaches BEAT_COUNT, move to Done.
  - busReadValid with no outstanding beat is ignored.
- Done:
  - Asserts memWriteDone or memReadDone according to op. memReadValue=line. Next state is Idle.
  - Enables are not sampled in Done. The initiator drops its enable in the cycle after done.
- memReadValue is driven from the line register at all times. It is meaningful only while memReadDone is high.
- busValid, once asserted, stays asserted with a stable address and data until accepted.

## Timing
- Reset values: state=Idle, all counters 0, line=0, addr=0. Every output is 0, including memReadValue, busAddr and busWriteData.
- rstN low at a clock edge returns the block to Idle from any state and discards the transfer in progress. busValid is 0 from the following cycle.
- Outputs are decoded from registered state only. There is no combinational path from busReady or busReadValid to any output.
- Write latency with busReady held at 1: request seen in cycle 0, beats in cycles 1..BEAT_COUNT, memWriteDone in cycle BEAT_COUNT+1.
- Read: memReadDone comes 1 cycle after the registered last response.
- Back-to-back requests: the earliest next acceptance is in the Idle cycle after Done.

## Configuration
- LINE_MEM_RESPONDER_PIPELINED_READ_EN defined:
  - Read beats are issued back-to-back; outstanding beats up to BEAT_COUNT.
  - busValid = (reqCount<BEAT_COUNT).
  - With busReady=1 and fixed response latency L, memReadDone comes in cycle BEAT_COUNT+L+1.
- Undefined:
  - At most one outstanding read beat; busValid = (reqCount==respCount && reqCount<BEAT_COUNT).
  - memReadDone comes in cycle BEAT_COUNT*(L+1)+1.
- Write behaviour is identical in both builds.

## Test plan
- Write, busReady=1, memAddr=0x0000010, line 0x33333333_22222222_11111111_00000000 -> beats to addresses 0x40, 0x41, 0x42, 0x43 with data 0x00000000, 0x11111111, 0x22222222, 0x33333333; memWriteDone pulses in cycle 5 only.
- Read, memAddr=0x0000002, responses 0xA0..0xA3 with latency 2 -> memReadValue=0x000000A3_000000A2_000000A1_000000A0 during the single memReadDone cycle. Done in cycle 7 with the macro, cycle 13 without.
- Write with busReady low for 3 cycles on beat 1 -> busValid, busAddr and busWriteData held stable through the stall; memWriteDone delayed by 3 cycles.
- memReadEnable and memWriteEnable high together -> write completes first; the read is then accepted in the Idle cycle after Done and completes normally.
- rstN low for one cycle after 2 read responses -> all outputs 0 and no done pulse. A new read afterwards returns the correct line, and the 2 stale responses are not used.
- Stray busReadValid in Idle -> ignored; memReadValue unchanged and no done pulse.
